// File: rtl/spi_dac_frame_monitor.sv
// spi_dac_frame_monitor
//   Passive snooper for the laser-driver DAC SPI bus. Each frame is
//   deserialized MSB first and decoded into cmd/code/pad fields. Short and
//   long frames are flagged. A good-frame counter and the last non-zero
//   code are kept for readback and interlock.
//
// Optional feature macro: LIMIT_CHECK_EN
//   defined   : good frames with code > drive_current_limit set over_limit
//               (sticky until clr_status)
//   undefined : over_limit tied low, no comparator built
//
// Ports
//   clk, rst             system clock, async active-high reset
//   spi_sck/ss/mosi      snooped bus, async to clk (clk >= 4x sck)
//   drive_current_limit  limit code, static between frames
//   clr_status           pulse, clears err_sticky / over_limit
//   frame_valid/err      one-cycle result pulses
//   frame_cmd/code/pad   fields of the last good frame
//   err_sticky           sticky framing error
//   over_limit           sticky over-limit flag
//   frame_count          good-frame counter (wraps)
//   last_on_code         last non-zero frame_code
module spi_dac_frame_monitor #(
  parameter int SYNC_STAGES = 2,  // must be >= 2
  parameter bit SAMPLE_FALL = 1'b1,
  parameter int FRAME_BITS  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_ss,
  input  logic        spi_mosi,
  input  logic [15:0] drive_current_limit,
  input  logic        clr_status,
  output logic        frame_valid,
  output logic [3:0]  frame_cmd,
  output logic [15:0] frame_code,
  output logic [3:0]  frame_pad,
  output logic        frame_err,
  output logic        err_sticky,
  output logic        over_limit,
  output logic [15:0] frame_count,
  output logic [15:0] last_on_code
);

  localparam logic [4:0] FRAME_BITS_W = 5'(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_ARM,
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, ss_prev_q;

  state_t                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   err_sticky_q, err_sticky_d;
  logic [3:0]             cmd_q, cmd_d;
  logic [15:0]            code_q, code_d;
  logic [3:0]             pad_q, pad_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [15:0]            last_on_code_q, last_on_code_d;

  logic        sck_s, ss_s, mosi_s;
  logic        sck_rise, sck_fall, ss_rise, ss_fall, sample;
  logic [15:0] shreg_code;

  // Synchronized values are the last chain stage; the *_prev flops sit one
  // stage behind it so edges are seen with SYNC_STAGES+2 total latency from
  // the pin to the result pulses.
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;
  assign sample   = SAMPLE_FALL ? sck_fall : sck_rise;

  assign shreg_code = shreg_q[FRAME_BITS-5 -: 16];

  assign sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
  assign ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};

`ifdef LIMIT_CHECK_EN
  logic over_q, over_d;
`else
  logic unused_limit;
  assign unused_limit = ^drive_current_limit;
`endif

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    cnt_d          = cnt_q;
    valid_d        = 1'b0;
    err_d          = 1'b0;
    cmd_d          = cmd_q;
    code_d         = code_q;
    pad_d          = pad_q;
    frame_count_d  = frame_count_q;
    last_on_code_d = last_on_code_q;
    // Clear first; any set below overrides it in the same cycle.
    err_sticky_d   = err_sticky_q & ~clr_status;
`ifdef LIMIT_CHECK_EN
    over_d         = over_q & ~clr_status;
`endif

    unique case (state_q)
      ST_ARM: begin
        // Sync chain resets to 0, so a frame in flight at reset release
        // keeps us here until ss is seen high.
        if (ss_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (ss_fall) begin
          cnt_d   = '0;
          shreg_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sample) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_s};
          if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end
        if (ss_rise) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (cnt_q == FRAME_BITS_W) begin
          cmd_d         = shreg_q[FRAME_BITS-1 -: 4];
          code_d        = shreg_code;
          pad_d         = shreg_q[3:0];
          valid_d       = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          if (shreg_code != 16'd0) last_on_code_d = shreg_code;
`ifdef LIMIT_CHECK_EN
          if (shreg_code > drive_current_limit) over_d = 1'b1;
`endif
        end else begin
          err_d        = 1'b1;
          err_sticky_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q     <= '0;
      ss_sync_q      <= '0;
      mosi_sync_q    <= '0;
      sck_prev_q     <= 1'b0;
      ss_prev_q      <= 1'b0;
      state_q        <= ST_ARM;
      shreg_q        <= '0;
      cnt_q          <= '0;
      valid_q        <= 1'b0;
      err_q          <= 1'b0;
      err_sticky_q   <= 1'b0;
      cmd_q          <= '0;
      code_q         <= '0;
      pad_q          <= '0;
      frame_count_q  <= '0;
      last_on_code_q <= '0;
    end else begin
      sck_sync_q     <= sck_sync_d;
      ss_sync_q      <= ss_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      sck_prev_q     <= sck_s;
      ss_prev_q      <= ss_s;
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      cnt_q          <= cnt_d;
      valid_q        <= valid_d;
      err_q          <= err_d;
      err_sticky_q   <= err_sticky_d;
      cmd_q          <= cmd_d;
      code_q         <= code_d;
      pad_q          <= pad_d;
      frame_count_q  <= frame_count_d;
      last_on_code_q <= last_on_code_d;
    end
  end

`ifdef LIMIT_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) over_q <= 1'b0;
    else     over_q <= over_d;
  end
  assign over_limit = over_q;
`else
  assign over_limit = 1'b0;
`endif

  assign frame_valid  = valid_q;
  assign frame_err    = err_q;
  assign err_sticky   = err_sticky_q;
  assign frame_cmd    = cmd_q;
  assign frame_code   = code_q;
  assign frame_pad    = pad_q;
  assign frame_count  = frame_count_q;
  assign last_on_code = last_on_code_q;

endmodule
